// File: rtl/mem_io_ctrl.sv
// Data-side memory/I-O controller: decodes CPU data addresses into RAM, screen and
// keyboard regions, and buffers keyboard codes in a small memory-mapped FIFO.
module mem_io_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addrM,
    input  logic [15:0] outM,
    input  logic        wrtM,
    output logic [15:0] inM,
    output logic [13:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    output logic [12:0] scr_addr,
    output logic [15:0] scr_wdata,
    output logic        scr_we,
    input  logic [15:0] kbd_data,
    input  logic        kbd_valid,
    output logic        kbd_ready
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        R_NONE,
        R_RAM,
        R_SCR,
        R_KDATA,
        R_KSTAT
    } region_t;

    region_t       region;
    region_t       region_q;
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   kdata_q;
    logic [15:0]   kstat_q;
    logic          empty;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;

    always_comb begin
        region = R_NONE;
        if (addrM[15:14] == 2'b00)
            region = R_RAM;
        else if (addrM[15:13] == 3'b010)
            region = R_SCR;
        else if (addrM == 16'h6000)
            region = R_KDATA;
        else if (addrM == 16'h6001)
            region = R_KSTAT;
    end

    assign ram_addr  = addrM[13:0];
    assign ram_wdata = outM;
    assign scr_addr  = addrM[12:0];
    assign scr_wdata = outM;
    assign ram_we    = !reset && wrtM && (region == R_RAM);
    assign scr_we    = !reset && wrtM && (region == R_SCR);

    assign empty     = (count == '0);
    assign kbd_ready = (count != FULL);
    assign push      = kbd_valid && kbd_ready;
    assign pop       = wrtM && (region == R_KDATA) && !empty;
    assign ovf_set   = kbd_valid && !kbd_ready;
    assign ovf_clr   = wrtM && (region == R_KSTAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            region_q <= R_NONE;
            kdata_q  <= '0;
            kstat_q  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            region_q <= region;
            // Head and status are snapshotted before this edge's push/pop take effect.
            kdata_q  <= empty ? '0 : fifo_mem[rd_ptr];
            kstat_q  <= {overflow, {(15 - CW){1'b0}}, count};
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (ovf_clr)
                overflow <= 1'b0;
            else if (ovf_set)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= kbd_data;
    end

    // RAM data arrives from the synchronous RAM's own output register, so all
    // regions share the same one-cycle read latency.
    always_comb begin
        inM = '0;
        case (region_q)
            R_RAM:   inM = ram_rdata;
            R_KDATA: inM = kdata_q;
            R_KSTAT: inM = kstat_q;
            default: inM = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: a queue-and-array reference model predicts
// each read response; a monitor process compares inM one cycle later.
module tb_mem_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addrM;
    logic [15:0] outM;
    logic        wrtM;
    logic [15:0] inM;
    logic [13:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [12:0] scr_addr;
    logic [15:0] scr_wdata;
    logic        scr_we;
    logic [15:0] kbd_data;
    logic        kbd_valid;
    logic        kbd_ready;

    always #5 clk = ~clk;

    mem_io_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .addrM     (addrM),
        .outM      (outM),
        .wrtM      (wrtM),
        .inM       (inM),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .scr_addr  (scr_addr),
        .scr_wdata (scr_wdata),
        .scr_we    (scr_we),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready)
    );

    // Synchronous RAM attached to the controller (read returns pre-write contents).
    logic [15:0] tb_ram [0:16383];
    always @(posedge clk) begin
        if (ram_we)
            tb_ram[ram_addr] <= ram_wdata;
        ram_rdata <= tb_ram[ram_addr];
    end

    typedef struct {
        logic [15:0] exp;
        string       tag;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] kq [$];
    logic        ovf_m;
    logic [15:0] mref [int];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({"inM_", e.tag}, inM, e.exp);
            end
        end
    end

    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w,
                        input logic kv, input logic [15:0] kd);
        exp_t       e;
        logic       known;
        int         sz;
        logic [2:0] sz3;
        logic       is_ram;
        logic       is_scr;
        @(negedge clk);
        addrM     = a;
        outM      = d;
        wrtM      = w;
        kbd_valid = kv;
        kbd_data  = kd;
        sz        = kq.size();
        sz3       = 3'(sz);
        is_ram    = (a < 16'h4000);
        is_scr    = (a >= 16'h4000) && (a < 16'h6000);
        known     = 1'b1;
        if (is_ram) begin
            known = mref.exists(int'(a));
            e.exp = known ? mref[int'(a)] : 16'h0000;
            e.tag = "ram";
        end else if (is_scr) begin
            e.exp = 16'h0000;
            e.tag = "scr";
        end else if (a == 16'h6000) begin
            e.exp = (sz > 0) ? kq[0] : 16'h0000;
            e.tag = "kdata";
        end else if (a == 16'h6001) begin
            e.exp = {ovf_m, 12'b0, sz3};
            e.tag = "kstat";
        end else begin
            e.exp = 16'h0000;
            e.tag = "none";
        end
        #1;
        chk("kbd_ready", 16'(kbd_ready), 16'(sz != 4));
        chk("ram_we", 16'(ram_we), 16'(w && is_ram));
        chk("scr_we", 16'(scr_we), 16'(w && is_scr));
        if (w && is_ram) begin
            chk("ram_addr", 16'(ram_addr), {2'b00, a[13:0]});
            chk("ram_wdata", ram_wdata, d);
        end
        if (w && is_scr) begin
            chk("scr_addr", 16'(scr_addr), {3'b000, a[12:0]});
            chk("scr_wdata", scr_wdata, d);
        end
        if (known)
            sb.push_back(e);
        if (w && a == 16'h6000 && sz > 0)
            void'(kq.pop_front());
        if (kv && sz < 4)
            kq.push_back(kd);
        if (w && a == 16'h6001)
            ovf_m = 1'b0;
        else if (kv && sz == 4)
            ovf_m = 1'b1;
        if (w && is_ram)
            mref[int'(a)] = d;
    endtask

    task automatic fill(input logic [15:0] base);
        for (int i = 0; i < 4; i++)
            step(16'h7000, 16'h0, 1'b0, 1'b1, base + 16'(i));
    endtask

    task automatic drain();
        repeat (5) step(16'h6000, 16'h0, 1'b1, 1'b0, 16'h0);
        step(16'h6001, 16'h0, 1'b1, 1'b0, 16'h0);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #4;
        reset  = 1'b1;
        addrM  = 16'h0020;
        outM   = 16'hDEAD;
        wrtM   = 1'b1;
        kbd_valid = 1'b0;
        sb.delete();
        kq.delete();
        ovf_m = 1'b0;
        #1;
        chk("rst_inM", inM, 16'h0000);
        chk("rst_kbd_ready", 16'(kbd_ready), 16'h0001);
        chk("rst_ram_we", 16'(ram_we), 16'h0000);
        @(posedge clk);
        #1;
        chk("rst_ram_we_edge", 16'(ram_we), 16'h0000);
        chk("rst_inM_edge", inM, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        wrtM  = 1'b0;
        addrM = 16'h7000;
        @(posedge clk);
        #1;
        chk("post_rst_inM", inM, 16'h0000);
    endtask

    initial begin
        logic [15:0] a;
        int          r;
        reset     = 1'b1;
        addrM     = 16'h0000;
        outM      = 16'hBEEF;
        wrtM      = 1'b1;
        kbd_valid = 1'b0;
        kbd_data  = 16'h0;
        ovf_m     = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_inM", inM, 16'h0000);
        chk("reset_kbd_ready", 16'(kbd_ready), 16'h0001);
        chk("reset_ram_we", 16'(ram_we), 16'h0000);
        chk("reset_scr_we", 16'(scr_we), 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        wrtM  = 1'b0;

        for (int i = 0; i < 32; i++)
            step(16'(i), 16'($urandom), 1'b1, 1'b0, 16'h0);

        // RAM round-trip and screen write/readback
        step(16'h0010, 16'h1234, 1'b1, 1'b0, 16'h0);
        step(16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0);
        step(16'h4005, 16'hFFFF, 1'b1, 1'b0, 16'h0);
        step(16'h4005, 16'h0000, 1'b0, 1'b0, 16'h0);

        // FIFO fill and drain
        fill(16'h0041);
        step(16'h6001, 16'h0, 1'b0, 1'b0, 16'h0);
        repeat (4) step(16'h6000, 16'h0, 1'b1, 1'b0, 16'h0);
        step(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0);

        // Overflow and sticky clear
        fill(16'h0041);
        step(16'h7000, 16'h0, 1'b0, 1'b1, 16'h0055);
        step(16'h6001, 16'h0, 1'b0, 1'b0, 16'h0);
        step(16'h6001, 16'h0, 1'b1, 1'b0, 16'h0);
        step(16'h6001, 16'h0, 1'b0, 1'b0, 16'h0);
        drain();

        // Simultaneous push/pop on empty, then on full
        step(16'h6000, 16'h0, 1'b1, 1'b1, 16'h0061);
        step(16'h6001, 16'h0, 1'b0, 1'b0, 16'h0);
        step(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0);
        drain();
        fill(16'h0071);
        step(16'h6000, 16'h0, 1'b1, 1'b1, 16'h0099);
        step(16'h6001, 16'h0, 1'b0, 1'b0, 16'h0);
        drain();

        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4 || r == 9)
                a = 16'($urandom_range(0, 31));
            else if (r == 4)
                a = 16'h4000 + 16'($urandom_range(0, 16'h1FFF));
            else if (r < 7)
                a = 16'h6000;
            else if (r == 7)
                a = 16'h6001;
            else
                a = 16'($urandom_range(16'h6002, 16'hFFFF));
            step(a, 16'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1), 16'($urandom));
        end

        // Mid-operation reset with count=3 and a RAM read in flight
        drain();
        for (int i = 0; i < 3; i++)
            step(16'h7000, 16'h0, 1'b0, 1'b1, 16'h0081 + 16'(i));
        step(16'h0010, 16'h0, 1'b0, 1'b0, 16'h0);
        reset_mid();
        step(16'h6001, 16'h0, 1'b0, 1'b0, 16'h0);
        step(16'h6000, 16'h0, 1'b0, 1'b0, 16'h0);
        step(16'h0010, 16'h0, 1'b0, 1'b0, 16'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 16'(sb.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
